mem_port_ctrl: RTL and testbench

MEM_PORT_CTRL -- requirements
Module: mem_port_ctrl

---
 rtl/mem_port_ctrl.sv | 99 +++++++++
 tb/tb_mem_port_ctrl.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_ctrl.sv
// Valid/ready request front-end for one port of a dual-port memory wrapper.
// Reads are credit-limited so the response FIFO can never overflow.
module mem_port_ctrl #(
  parameter int unsigned MEM_DATAWIDTH = 128,
  parameter int unsigned MEM_ADDRWIDTH = 14,
  parameter int unsigned RD_LATENCY    = 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic                           req_we,
  input  logic [(MEM_DATAWIDTH+7)/8-1:0] req_be,
  input  logic [MEM_ADDRWIDTH-1:0]       req_addr,
  input  logic [MEM_DATAWIDTH-1:0]       req_wdata,
  output logic                           rsp_valid,
  input  logic                           rsp_ready,
  output logic [MEM_DATAWIDTH-1:0]       rsp_rdata,
  output logic                           mem_en,
  output logic [(MEM_DATAWIDTH+7)/8-1:0] mem_we,
  output logic [MEM_ADDRWIDTH-1:0]       mem_addr,
  output logic [MEM_DATAWIDTH-1:0]       mem_wdata,
  input  logic [MEM_DATAWIDTH-1:0]       mem_rdata
);

  localparam int unsigned DEPTH = RD_LATENCY + 2;
  localparam int unsigned CW    = $clog2(DEPTH + 1);
  localparam int unsigned PW    = $clog2(DEPTH);

  logic [CW-1:0]            cnt_q, cnt_d;
  logic [CW-1:0]            fcnt_q, fcnt_d;
  logic [PW-1:0]            wptr_q, wptr_d, rptr_q, rptr_d;
  logic [RD_LATENCY-1:0]    vld_q, vld_d;
  logic [MEM_DATAWIDTH-1:0] buf_q [DEPTH];

  logic accept, rd_acc, push, pop;

  // Gated by reset so nothing is accepted or presented while reset is held.
  assign req_ready = !reset && (cnt_q < CW'(DEPTH));
  assign accept    = req_valid && req_ready;
  assign rd_acc    = accept && !req_we;

  assign mem_en    = accept;
  assign mem_we    = (accept && req_we) ? req_be : '0;
  assign mem_addr  = req_addr;
  assign mem_wdata = req_wdata;

  assign push      = vld_q[RD_LATENCY-1];
  assign rsp_valid = !reset && (fcnt_q != '0);
  assign pop       = rsp_valid && rsp_ready;
  assign rsp_rdata = buf_q[rptr_q];

  always_comb begin
    cnt_d = cnt_q;
    if (rd_acc && !pop)
      cnt_d = cnt_q + CW'(1);
    else if (!rd_acc && pop)
      cnt_d = cnt_q - CW'(1);

    fcnt_d = fcnt_q;
    if (push && !pop)
      fcnt_d = fcnt_q + CW'(1);
    else if (!push && pop)
      fcnt_d = fcnt_q - CW'(1);

    wptr_d = wptr_q;
    if (push)
      wptr_d = (wptr_q == PW'(DEPTH - 1)) ? '0 : wptr_q + PW'(1);

    rptr_d = rptr_q;
    if (pop)
      rptr_d = (rptr_q == PW'(DEPTH - 1)) ? '0 : rptr_q + PW'(1);

    vld_d = RD_LATENCY'({vld_q, rd_acc});
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      fcnt_q <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      vld_q  <= '0;
    end else begin
      cnt_q  <= cnt_d;
      fcnt_q <= fcnt_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      vld_q  <= vld_d;
      assert (!(push && !pop && (fcnt_q == CW'(DEPTH))));
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      buf_q[wptr_q] <= mem_rdata;
  end

endmodule

// File: tb/tb_mem_port_ctrl.sv
// Self-checking bench for mem_port_ctrl: behavioural memory behind the port and a
// scoreboard (shadow memory + expected-response queue) derived from request order.
module tb_mem_port_ctrl;

  localparam int unsigned DW    = 128;
  localparam int unsigned AW    = 14;
  localparam int unsigned LAT   = 2;
  localparam int unsigned DEPTH = LAT + 2;
  localparam int unsigned BW    = (DW + 7) / 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_we = 1'b0;
  logic          rsp_ready = 1'b0;
  logic [BW-1:0] req_be = '0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          req_ready, rsp_valid, mem_en;
  logic [DW-1:0] rsp_rdata, mem_wdata, mem_rdata;
  logic [BW-1:0] mem_we;
  logic [AW-1:0] mem_addr;

  int ncmp = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  mem_port_ctrl #(.MEM_DATAWIDTH(DW), .MEM_ADDRWIDTH(AW), .RD_LATENCY(LAT)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_be(req_be),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // Memory wrapper port: data for a read issued in cycle t appears in cycle t+LAT.
  bit   [DW-1:0] mem   [1<<AW];
  logic [DW-1:0] rpipe [LAT];
  assign mem_rdata = rpipe[LAT-1];

  always @(posedge clk) begin
    logic [DW-1:0] w;
    w = mem[mem_addr];
    if (mem_en) begin
      for (int b = 0; b < BW; b++)
        if (mem_we[b]) w[b*8 +: 8] = mem_wdata[b*8 +: 8];
      mem[mem_addr] <= w;
    end
    rpipe[0] <= mem_en ? mem[mem_addr] : 'x;
    for (int i = 1; i < LAT; i++) rpipe[i] <= rpipe[i-1];
  end

  bit   [DW-1:0] ref_mem [1<<AW];
  logic [DW-1:0] exp_q   [$];

  // Scoreboard update for the current cycle (called at the negative edge).
  task automatic model_obs();
    if (req_valid && req_ready) begin
      if (req_we) begin
        for (int b = 0; b < BW; b++)
          if (req_be[b]) ref_mem[req_addr][b*8 +: 8] = req_wdata[b*8 +: 8];
      end else begin
        exp_q.push_back(ref_mem[req_addr]);
      end
    end
  endtask

  task automatic cyc(input logic v, input logic we, input logic [BW-1:0] be,
                     input logic [AW-1:0] a, input logic [DW-1:0] d, input logic rr);
    @(posedge clk); #1;
    req_valid = v; req_we = we; req_be = be; req_addr = a; req_wdata = d; rsp_ready = rr;
    @(negedge clk);
  endtask

  function automatic logic [DW-1:0] rnd_data();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b1, '1, AW'(5), '1, 1'b1);
      ncmp++;
      if ({req_ready, rsp_valid, mem_en, (mem_we != '0)} !== 4'b0000) begin
        nerr++;
        $display("FAIL reset_outputs: ready/rvalid/en/we_any=%b required 0000",
                 {req_ready, rsp_valid, mem_en, (mem_we != '0)});
      end
      model_obs();
    end
    @(posedge clk); #1; reset = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    ncmp++;
    if ({req_ready, rsp_valid} !== 2'b10) begin
      nerr++;
      $display("FAIL reset_release: ready/rvalid=%b required 10", {req_ready, rsp_valid});
    end
    exp_q.delete();
  endtask

  task automatic test_write_read();
    logic [DW-1:0] pat;
    pat = {BW{8'hA5}};
    cyc(1'b1, 1'b1, '1, AW'('h10), pat, 1'b1);
    ncmp++;
    if (mem_en !== 1'b1 || mem_we !== {BW{1'b1}} || mem_addr !== AW'('h10) || mem_wdata !== pat) begin
      nerr++;
      $display("FAIL write_port: en=%b we=%h addr=%h wdata=%h required 1/all-ones/010/a5..",
               mem_en, mem_we, mem_addr, mem_wdata);
    end
    model_obs();
    cyc(1'b0, 1'b0, '1, AW'('h10), '0, 1'b1);
    ncmp++;
    if (mem_en !== 1'b0 || mem_we !== '0) begin
      nerr++;
      $display("FAIL idle_port: en=%b we=%h required 0/0", mem_en, mem_we);
    end
    model_obs();
    cyc(1'b1, 1'b0, '1, AW'('h10), '0, 1'b1);
    ncmp++;
    if (mem_en !== 1'b1 || mem_we !== '0) begin
      nerr++;
      $display("FAIL read_port: en=%b we=%h required 1/0", mem_en, mem_we);
    end
    model_obs();
    for (int k = 1; k <= int'(LAT) + 1; k++) begin
      cyc(1'b0, 1'b0, '0, '0, '0, 1'b1);
      ncmp++;
      if (rsp_valid !== (k == int'(LAT) + 1)) begin
        nerr++;
        $display("FAIL read_latency: cycle accept+%0d rsp_valid=%b required %b",
                 k, rsp_valid, (k == int'(LAT) + 1));
      end
      if (rsp_valid && rsp_ready) begin
        void'(exp_q.pop_front());
        ncmp++;
        if (rsp_rdata !== pat) begin
          nerr++;
          $display("FAIL write_read_data: got %h required %h", rsp_rdata, pat);
        end
      end
      model_obs();
    end
  endtask

  task automatic test_byte_enable();
    logic [DW-1:0] want;
    bit got;
    want = DW'(8'hFF);
    got = 1'b0;
    cyc(1'b1, 1'b1, '1, AW'('h20), '0, 1'b1);
    model_obs();
    cyc(1'b1, 1'b1, BW'(16'h0001), AW'('h20), '1, 1'b1);
    model_obs();
    cyc(1'b1, 1'b0, '0, AW'('h20), '0, 1'b1);
    model_obs();
    for (int k = 0; k < 10 && !got; k++) begin
      cyc(1'b0, 1'b0, '0, '0, '0, 1'b1);
      if (rsp_valid && rsp_ready) begin
        got = 1'b1;
        void'(exp_q.pop_front());
        ncmp++;
        if (rsp_rdata !== want) begin
          nerr++;
          $display("FAIL byte_enable: got %h required %h", rsp_rdata, want);
        end
      end
      model_obs();
    end
    if (!got) begin
      ncmp++; nerr++;
      $display("FAIL byte_enable_timeout: rsp_valid=0 after 10 cycles, required a response");
    end
  endtask

  task automatic test_backpressure();
    int acc = 0;
    int nresp = 0;
    logic [DW-1:0] e;
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 1'b1, '1, AW'('h30 + i), rnd_data(), 1'b0);
      model_obs();
    end
    for (int i = 0; i < 12; i++) begin
      cyc(1'b1, 1'b0, '0, AW'('h30 + (acc % 4)), '0, 1'b0);
      if (req_valid && req_ready) acc++;
      model_obs();
    end
    ncmp++;
    if (acc != int'(DEPTH)) begin
      nerr++;
      $display("FAIL bp_accepts: %0d accepted, required %0d", acc, DEPTH);
    end
    ncmp++;
    if (req_ready !== 1'b0) begin
      nerr++;
      $display("FAIL bp_stall: req_ready=%b required 0", req_ready);
    end
    for (int i = 0; i < int'(DEPTH) + 4; i++) begin
      cyc(1'b0, 1'b0, '0, '0, '0, 1'b1);
      if (i < 2) begin
        ncmp++;
        if (req_ready !== (i == 1)) begin
          nerr++;
          $display("FAIL bp_ready_rise: release cycle %0d req_ready=%b required %b",
                   i, req_ready, (i == 1));
        end
      end
      if (rsp_valid && rsp_ready) begin
        nresp++;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
        ncmp++;
        if (rsp_rdata !== e) begin
          nerr++;
          $display("FAIL bp_order: response %0d got %h required %h", nresp, rsp_rdata, e);
        end
      end
      model_obs();
    end
    ncmp++;
    if (nresp != int'(DEPTH) || req_ready !== 1'b1) begin
      nerr++;
      $display("FAIL bp_drain: %0d responses ready=%b, required %0d / 1", nresp, req_ready, DEPTH);
    end
  endtask

  task automatic test_back_to_back();
    int acc = 0;
    int nresp = 0;
    int first = -1;
    int last = -1;
    logic [DW-1:0] e;
    for (int i = 0; i < 100; i++) begin
      cyc(1'b1, 1'b1, '1, AW'(i), rnd_data(), 1'b1);
      model_obs();
    end
    for (int i = 0; i < 100 + int'(LAT) + 8; i++) begin
      cyc(i < 100, 1'b0, '0, AW'(i), '0, 1'b1);
      if (i < 100 && req_valid && req_ready) acc++;
      if (rsp_valid && rsp_ready) begin
        if (first < 0) first = i;
        last = i;
        nresp++;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
        ncmp++;
        if (rsp_rdata !== e) begin
          nerr++;
          $display("FAIL b2b_data: response %0d got %h required %h", nresp, rsp_rdata, e);
        end
      end
      model_obs();
    end
    ncmp++;
    if (acc != 100) begin
      nerr++;
      $display("FAIL b2b_accepts: %0d accepts in 100 cycles, required 100", acc);
    end
    ncmp++;
    if (nresp != 100 || (last - first) != 99) begin
      nerr++;
      $display("FAIL b2b_gapless: %0d responses over %0d cycles, required 100 over 100",
               nresp, last - first + 1);
    end
  endtask

  task automatic test_reset_inflight();
    int nval = 0;
    int acc = 0;
    int nresp = 0;
    logic [DW-1:0] e;
    cyc(1'b1, 1'b0, '0, AW'(1), '0, 1'b1); model_obs();
    cyc(1'b1, 1'b0, '0, AW'(2), '0, 1'b1); model_obs();
    @(posedge clk); #1; reset = 1'b1; req_valid = 1'b1;
    @(negedge clk);
    ncmp++;
    if ({rsp_valid, mem_en} !== 2'b00) begin
      nerr++;
      $display("FAIL rst_mid_outputs: rvalid/en=%b required 00", {rsp_valid, mem_en});
    end
    exp_q.delete();
    @(posedge clk); #1; reset = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    ncmp++;
    if (req_ready !== 1'b1) begin
      nerr++;
      $display("FAIL rst_mid_ready: req_ready=%b required 1", req_ready);
    end
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 1'b0, '0, '0, '0, 1'b1);
      if (rsp_valid) nval++;
    end
    ncmp++;
    if (nval != 0) begin
      nerr++;
      $display("FAIL rst_mid_discard: rsp_valid seen %0d cycles, required 0", nval);
    end
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, 1'b0, '0, AW'($urandom_range(0, 99)), '0, 1'b0);
      if (req_valid && req_ready) acc++;
      model_obs();
    end
    ncmp++;
    if (acc != int'(DEPTH)) begin
      nerr++;
      $display("FAIL rst_mid_credits: %0d accepted after reset, required %0d", acc, DEPTH);
    end
    for (int i = 0; i < int'(DEPTH) + 4; i++) begin
      cyc(1'b0, 1'b0, '0, '0, '0, 1'b1);
      if (rsp_valid && rsp_ready) begin
        nresp++;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
        ncmp++;
        if (rsp_rdata !== e) begin
          nerr++;
          $display("FAIL rst_mid_data: response %0d got %h required %h", nresp, rsp_rdata, e);
        end
      end
      model_obs();
    end
  endtask

  task automatic test_random();
    int nacc = 0;
    int ncyc = 0;
    logic [DW-1:0] e;
    while (nacc < 10000 && ncyc < 60000) begin
      cyc($urandom_range(0, 99) < 70, $urandom_range(0, 2) == 0, BW'($urandom),
          AW'($urandom_range(0, 31)), rnd_data(), $urandom_range(0, 99) < 60);
      if (rsp_valid && rsp_ready) begin
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
        ncmp++;
        if (rsp_rdata !== e) begin
          nerr++;
          $display("FAIL random_data: cycle %0d got %h required %h", ncyc, rsp_rdata, e);
        end
      end
      if (req_valid && req_ready) nacc++;
      model_obs();
      ncyc++;
    end
    ncmp++;
    if (nacc != 10000) begin
      nerr++;
      $display("FAIL random_budget: %0d requests accepted in %0d cycles, required 10000", nacc, ncyc);
    end
    for (int i = 0; i < 20; i++) begin
      cyc(1'b0, 1'b0, '0, '0, '0, 1'b1);
      if (rsp_valid && rsp_ready) begin
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
        ncmp++;
        if (rsp_rdata !== e) begin
          nerr++;
          $display("FAIL random_drain: got %h required %h", rsp_rdata, e);
        end
      end
      model_obs();
    end
    ncmp++;
    if (exp_q.size() != 0 || rsp_valid !== 1'b0) begin
      nerr++;
      $display("FAIL random_leftover: %0d responses outstanding rvalid=%b, required 0/0",
               exp_q.size(), rsp_valid);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_byte_enable();
    test_backpressure();
    test_back_to_back();
    test_reset_inflight();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
